dm_write_buffer: RTL and testbench

//  Posted-write FIFO between the DM cache control FSM (write-through) and the DM AXI master FSM.

---
 rtl/dm_write_buffer.sv | 143 ++++++++++++++
 tb/tb_dm_write_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_write_buffer.sv
// dm_write_buffer: posted-write FIFO between cache FSM and AXI master, with read bypass and RAW ordering
module dm_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up_aw_valid,
  input  logic [ADDR_W-1:0]   up_write_addr,
  input  logic [DATA_W-1:0]   up_write_data,
  input  logic [DATA_W/8-1:0] up_write_bweb,
  output logic                up_write_done,
  input  logic                up_ar_valid,
  input  logic [ADDR_W-1:0]   up_read_addr,
  output logic                dn_aw_valid,
  output logic [ADDR_W-1:0]   dn_write_addr,
  output logic [DATA_W-1:0]   dn_write_data,
  output logic [DATA_W/8-1:0] dn_write_bweb,
  input  logic                dn_write_done,
  output logic                dn_ar_valid,
  output logic [ADDR_W-1:0]   dn_read_addr,
  input  logic                dn_rvalid,
  input  logic                dn_rlast,
  output logic                buf_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DATA_W / 8;
  localparam int EW = ADDR_W + DATA_W + BW;

  typedef enum logic [1:0] {IDLE, WRITE, READ, R_END} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic              up_write_done_q, up_write_done_d;
  logic              dn_aw_valid_q, dn_aw_valid_d;
  logic              dn_ar_valid_q, dn_ar_valid_d;
  logic              buf_empty_q, buf_empty_d;
  logic [ADDR_W-1:0] dn_write_addr_q, dn_write_addr_d;
  logic [ADDR_W-1:0] dn_read_addr_q, dn_read_addr_d;
  logic [DATA_W-1:0] dn_write_data_q, dn_write_data_d;
  logic [BW-1:0]     dn_write_bweb_q, dn_write_bweb_d;
  logic              push, pop, conflict, read_ok;
  logic [EW-1:0]     head;

  assign push    = up_aw_valid && (count_q < CW'(DEPTH)) && !up_write_done_q;
  assign pop     = (state_q == WRITE) && dn_write_done;
  assign head    = mem_q[rptr_q];
  assign read_ok = up_ar_valid && !conflict;

  // Word-address alias check of the read against every live entry, including one entering this cycle
  always_comb begin
    conflict = push && (up_write_addr[ADDR_W-1:2] == up_read_addr[ADDR_W-1:2]);
    for (int i = 0; i < DEPTH; i++)
      if ((CW'(PW'(PW'(i) - rptr_q)) < count_q) && (mem_q[PW'(i)][EW-1 -: ADDR_W-2] == up_read_addr[ADDR_W-1:2]))
        conflict = 1'b1;
  end

  // FIFO bookkeeping and downstream arbitration; full buffer beats reads, reads beat a partial drain
  always_comb begin
    state_d         = state_q;
    wptr_d          = wptr_q + PW'(push);
    rptr_d          = rptr_q + PW'(pop);
    count_d         = count_q + CW'(push) - CW'(pop);
    up_write_done_d = push;
    dn_aw_valid_d   = dn_aw_valid_q;
    dn_ar_valid_d   = dn_ar_valid_q;
    dn_write_addr_d = dn_write_addr_q;
    dn_write_data_d = dn_write_data_q;
    dn_write_bweb_d = dn_write_bweb_q;
    dn_read_addr_d  = dn_read_addr_q;
    case (state_q)
      IDLE:
        if (count_q == CW'(DEPTH) || (count_q != '0 && !read_ok)) begin
          state_d       = WRITE;
          dn_aw_valid_d = 1'b1;
          {dn_write_addr_d, dn_write_data_d, dn_write_bweb_d} = head;
        end else if (read_ok) begin
          state_d        = READ;
          dn_ar_valid_d  = 1'b1;
          dn_read_addr_d = up_read_addr;
        end
      WRITE:
        if (dn_write_done) begin
          state_d       = IDLE;
          dn_aw_valid_d = 1'b0;
        end
      READ:
        if (dn_rvalid && dn_rlast) begin
          state_d       = R_END;
          dn_ar_valid_d = 1'b0;
        end
      default: state_d = IDLE;
    endcase
    buf_empty_d = (count_d == '0) && (state_d != WRITE);
  end

  // Entry storage holds only payload, so it needs no reset
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= {up_write_addr, up_write_data, up_write_bweb};

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q         <= IDLE;
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      up_write_done_q <= 1'b0;
      dn_aw_valid_q   <= 1'b0;
      dn_ar_valid_q   <= 1'b0;
      buf_empty_q     <= 1'b1;
      dn_write_addr_q <= '0;
      dn_write_data_q <= '0;
      dn_write_bweb_q <= '0;
      dn_read_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      up_write_done_q <= up_write_done_d;
      dn_aw_valid_q   <= dn_aw_valid_d;
      dn_ar_valid_q   <= dn_ar_valid_d;
      buf_empty_q     <= buf_empty_d;
      dn_write_addr_q <= dn_write_addr_d;
      dn_write_data_q <= dn_write_data_d;
      dn_write_bweb_q <= dn_write_bweb_d;
      dn_read_addr_q  <= dn_read_addr_d;
    end

  assign up_write_done = up_write_done_q;
  assign dn_aw_valid   = dn_aw_valid_q;
  assign dn_ar_valid   = dn_ar_valid_q;
  assign buf_empty     = buf_empty_q;
  assign dn_write_addr = dn_write_addr_q;
  assign dn_write_data = dn_write_data_q;
  assign dn_write_bweb = dn_write_bweb_q;
  assign dn_read_addr  = dn_read_addr_q;
endmodule

// File: tb/tb_dm_write_buffer.sv
// tb_dm_write_buffer: scoreboard bench for dm_write_buffer with a downstream AXI-master model
module tb_dm_write_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_aw_valid = 1'b0;
  logic [AW-1:0] up_write_addr = '0;
  logic [DW-1:0] up_write_data = '0;
  logic [BW-1:0] up_write_bweb = '0;
  logic          up_write_done;
  logic          up_ar_valid = 1'b0;
  logic [AW-1:0] up_read_addr = '0;
  logic          dn_aw_valid;
  logic [AW-1:0] dn_write_addr;
  logic [DW-1:0] dn_write_data;
  logic [BW-1:0] dn_write_bweb;
  logic          dn_write_done = 1'b0;
  logic          dn_ar_valid;
  logic [AW-1:0] dn_read_addr;
  logic          dn_rvalid = 1'b0;
  logic          dn_rlast = 1'b0;
  logic          buf_empty;

  txn_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   hold_w = 1'b1;
  int   wlat = 1;
  int   pulse_cnt = 0;
  int   pulse_seen = 0;
  int   wcnt = 0;
  int   rb = 0;
  bit   pa = 1'b0;
  bit   pr = 1'b0;

  logic [AW-1:0] sa [4] = '{32'h200, 32'h104, 32'h104, 32'h104};
  logic [AW-1:0] ra [4] = '{32'h300, 32'h104, 32'h106, 32'h108};
  bit            cf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  dm_write_buffer dut (
    .clk(clk), .rst(rst),
    .up_aw_valid(up_aw_valid), .up_write_addr(up_write_addr), .up_write_data(up_write_data),
    .up_write_bweb(up_write_bweb), .up_write_done(up_write_done),
    .up_ar_valid(up_ar_valid), .up_read_addr(up_read_addr),
    .dn_aw_valid(dn_aw_valid), .dn_write_addr(dn_write_addr), .dn_write_data(dn_write_data),
    .dn_write_bweb(dn_write_bweb), .dn_write_done(dn_write_done),
    .dn_ar_valid(dn_ar_valid), .dn_read_addr(dn_read_addr),
    .dn_rvalid(dn_rvalid), .dn_rlast(dn_rlast), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
    txn_t t;
    t = '{1'b1, a, d, b};
    exp_q.push_back(t);
  endtask

  task automatic expr(input logic [AW-1:0] a);
    txn_t t;
    t = '{1'b0, a, '0, '0};
    exp_q.push_back(t);
  endtask

  // n = negedges until up_write_done is seen, 0 on timeout
  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b, output int n);
    @(posedge clk);
    #1;
    up_aw_valid = 1'b1;
    up_write_addr = a;
    up_write_data = d;
    up_write_bweb = b;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (up_write_done) begin
        n = i;
        break;
      end
    end
    up_aw_valid = 1'b0;
    if (n == 0) begin
      compared++;
      mismatched++;
      $display("FAIL store_timeout: got no up_write_done expected one for addr %0h", a);
    end
  endtask

  task automatic sw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b, output int n);
    expw(a, d, b);
    store(a, d, b, n);
  endtask

  task automatic read(input logic [AW-1:0] a);
    int ph;
    ph = 0;
    @(posedge clk);
    #1;
    up_ar_valid = 1'b1;
    up_read_addr = a;
    for (int i = 0; i < 200 && ph < 2; i++) begin
      @(negedge clk);
      if (ph == 0 && dn_ar_valid) ph = 1;
      else if (ph == 1 && !dn_ar_valid) ph = 2;
    end
    up_ar_valid = 1'b0;
    check("read_done", ph, 2);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (buf_empty && exp_q.size() == 0 && !dn_aw_valid && !dn_ar_valid) break;
    end
    check("drain_empty", {buf_empty, exp_q.size() == 0}, 2'b11);
  endtask

  // Downstream master model: answers writes after wlat cycles unless held, or on a one-shot request
  initial forever begin
    @(posedge clk);
    #1;
    dn_write_done = 1'b0;
    dn_rvalid = 1'b0;
    dn_rlast = 1'b0;
    if (rst) begin
      wcnt = 0;
      rb = 0;
    end else begin
      if (dn_aw_valid) begin
        if (pulse_seen != pulse_cnt || (!hold_w && wcnt >= wlat)) begin
          dn_write_done = 1'b1;
          wcnt = 0;
          pulse_seen = pulse_cnt;
        end else wcnt++;
      end else wcnt = 0;
      if (dn_ar_valid) begin
        dn_rvalid = 1'b1;
        dn_rlast = (rb == 3);
        rb = (rb == 3) ? 0 : rb + 1;
      end
    end
  end

  // Monitor: each new downstream transaction is popped from the scoreboard and compared
  initial forever begin
    txn_t g, e;
    @(negedge clk);
    if (dn_aw_valid && dn_ar_valid) begin
      compared++;
      mismatched++;
      $display("FAIL both_valid: got aw=1 ar=1 expected at most one");
    end
    if ((dn_aw_valid && !pa) || (dn_ar_valid && !pr)) begin
      if (dn_aw_valid) g = '{1'b1, dn_write_addr, dn_write_data, dn_write_bweb};
      else g = '{1'b0, dn_read_addr, '0, '0};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL txn_unexpected: got %0h expected none", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          mismatched++;
          $display("FAIL txn_order: got %0h expected %0h", g, e);
        end
      end
    end
    pa = dn_aw_valid;
    pr = dn_ar_valid;
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_aw_valid", dn_aw_valid, 0);
    check("rst_ar_valid", dn_ar_valid, 0);
    check("rst_write_done", up_write_done, 0);
    check("rst_buf_empty", buf_empty, 1);
    check("rst_write_addr", dn_write_addr, 0);
    check("rst_read_addr", dn_read_addr, 0);
    rst = 1'b0;
    // single store through an empty idle buffer
    hold_w = 1'b1;
    sw(32'h100, 32'hDEADBEEF, 4'h0, n);
    check("t1_done_lat", n, 2);
    @(negedge clk);
    check("t1_aw_valid", dn_aw_valid, 1);
    check("t1_done_pulse", up_write_done, 0);
    check("t1_not_empty", buf_empty, 0);
    repeat (4) @(negedge clk);
    check("t1_payload_hold", {dn_aw_valid, dn_write_addr, dn_write_data, dn_write_bweb}, {1'b1, 32'h100, 32'hDEADBEEF, 4'h0});
    hold_w = 1'b0;
    wait_drain();
    // fill past capacity with the drain held off
    hold_w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sw(32'h400 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'(i), n);
      check("t2_done_lat", n, 2);
    end
    expw(32'h410, 32'h1000_0004, 4'h4);
    fork
      store(32'h410, 32'h1000_0004, 4'h4, n);
      begin
        repeat (10) @(negedge clk);
        hold_w = 1'b0;
      end
    join
    check("t2_full_wait", n, 13);
    wait_drain();
    // read bypass and RAW conflicts on an entry pushed in the same cycle
    hold_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cf[i]) begin
        expw(sa[i], 32'hC0DE_0000 + 32'(i), 4'hC);
        expr(ra[i]);
      end else begin
        expr(ra[i]);
        expw(sa[i], 32'hC0DE_0000 + 32'(i), 4'hC);
      end
      fork
        store(sa[i], 32'hC0DE_0000 + 32'(i), 4'hC, n);
        read(ra[i]);
      join
      check("t3_done_lat", n, 2);
      wait_drain();
    end
    // read against entries already stored behind an in-flight write
    for (int i = 0; i < 2; i++) begin
      hold_w = 1'b1;
      sw(32'h500, 32'h5555_0000, 4'h0, n);
      if (i == 0) begin
        expw(32'h104, 32'h6666_0000, 4'hC);
        expr(32'h104);
      end else begin
        expr(32'h104);
        expw(32'h108, 32'h6666_0001, 4'hC);
      end
      store(i == 0 ? 32'h104 : 32'h108, 32'h6666_0000 + 32'(i), 4'hC, n);
      fork
        read(32'h104);
        begin
          repeat (3) @(negedge clk);
          hold_w = 1'b0;
        end
      join
      wait_drain();
    end
    // simultaneous push and pop at count 2, then no push on the pop cycle when full
    hold_w = 1'b1;
    sw(32'h800, 32'hA0, 4'h1, n);
    sw(32'h804, 32'hA1, 4'h2, n);
    expw(32'h808, 32'hA2, 4'h3);
    pulse_cnt++;
    store(32'h808, 32'hA2, 4'h3, n);
    check("t5_pushpop_lat", n, 2);
    sw(32'h80C, 32'hA3, 4'h4, n);
    check("t5_fill3_lat", n, 2);
    sw(32'h810, 32'hA4, 4'h5, n);
    check("t5_fill4_lat", n, 2);
    expw(32'h814, 32'hA5, 4'h6);
    fork
      store(32'h814, 32'hA5, 4'h6, n);
      begin
        repeat (8) @(negedge clk);
        pulse_cnt++;
      end
    join
    check("t5_full_pop_lat", n, 11);
    hold_w = 1'b0;
    wait_drain();
    // reset in the middle of a write with three entries buffered
    hold_w = 1'b1;
    expw(32'h600, 32'hB0, 4'h0);
    store(32'h600, 32'hB0, 4'h0, n);
    store(32'h604, 32'hB1, 4'h0, n);
    store(32'h608, 32'hB2, 4'h0, n);
    @(negedge clk);
    check("t6_aw_before", dn_aw_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_aw_dropped", dn_aw_valid, 0);
    check("t6_empty", buf_empty, 1);
    check("t6_done_low", up_write_done, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_w = 1'b0;
    sw(32'h700, 32'hCAFEF00D, 4'h9, n);
    check("t6_after_lat", n, 2);
    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
